// File: rtl/io_arbiter.sv
// io_arbiter: arbitrates NREQ requesters onto a single I/O port block.
// Each granted request runs one fixed four-state transaction:
// IDLE -> ACCESS (io_en pulse) -> CAPTURE (read data sampled) -> DONE (done pulse).
// Optional build macro: IO_ARB_CORE_PRIO_EN gives requester 0 (the core) absolute
// priority; the remaining requesters share round-robin among themselves.
// Without the macro, all requesters share a single round-robin.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   req, req_rw     per-requester level request and direction (1 = write)
//   req_addr        packed per-requester port addresses
//   req_wdata       packed per-requester write data
//   gnt, done       one-hot grant, one-cycle completion pulse
//   rdata           data of the last completed read
//   busy            high whenever a transaction is in flight
//   io_en, io_r_or_w, io_addr, io_data_in   request to the I/O port block
//   io_data_out     read data from the I/O port block (valid the cycle after io_en)
module io_arbiter #(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_rw,
  input  logic [NREQ*ADDR_BITS-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]     req_wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [WIDTH-1:0]          rdata,
  output logic                      busy,
  output logic                      io_en,
  output logic                      io_r_or_w,
  output logic [ADDR_BITS-1:0]      io_addr,
  output logic [WIDTH-1:0]          io_data_in,
  input  logic [WIDTH-1:0]          io_data_out
);

  localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef IO_ARB_CORE_PRIO_EN
  localparam bit CORE_PRIO = 1'b1;
`else
  localparam bit CORE_PRIO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_e;

  state_e                 state_q, state_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic [NREQ-1:0]        done_q, done_d;
  logic [WIDTH-1:0]       rdata_q, rdata_d;
  logic                   busy_q, busy_d;
  logic                   io_en_q, io_en_d;
  logic                   io_rw_q, io_rw_d;
  logic [ADDR_BITS-1:0]   io_addr_q, io_addr_d;
  logic [WIDTH-1:0]       io_wdata_q, io_wdata_d;
  logic                   lat_rw_q, lat_rw_d;
  logic [LW-1:0]          last_q, last_d;

  logic [LW-1:0]          win_c;
  logic                   found_c;

  // Winner selection: optional core override, then round-robin from last_q+1.
  always_comb begin
    win_c   = '0;
    found_c = 1'b0;
    if (CORE_PRIO && req[0]) begin
      win_c   = '0;
      found_c = 1'b1;
    end
    for (int unsigned i = 1; i <= NREQ; i++) begin
      int unsigned cand;
      cand = (32'(last_q) + i) % NREQ;
      if (!found_c && req[cand] && (!CORE_PRIO || cand != 0)) begin
        win_c   = LW'(cand);
        found_c = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    io_en_d    = 1'b0;
    io_rw_d    = 1'b0;
    io_addr_d  = '0;
    io_wdata_d = '0;
    lat_rw_d   = lat_rw_q;
    last_d     = last_q;

    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d        = ACCESS;
          gnt_d          = '0;
          gnt_d[win_c]   = 1'b1;
          busy_d         = 1'b1;
          last_d         = win_c;
          lat_rw_d       = req_rw[win_c];
          // Address/data are captured into the port-side flops here and
          // never re-sampled, so later input changes cannot leak in.
          io_en_d        = 1'b1;
          io_rw_d        = req_rw[win_c];
          io_addr_d      = req_addr[win_c*ADDR_BITS +: ADDR_BITS];
          io_wdata_d     = req_wdata[win_c*WIDTH +: WIDTH];
        end
      end
      ACCESS: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!lat_rw_q) begin
          rdata_d = io_data_out;
        end
        done_d[last_q] = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      io_en_q    <= 1'b0;
      io_rw_q    <= 1'b0;
      io_addr_q  <= '0;
      io_wdata_q <= '0;
      lat_rw_q   <= 1'b0;
      last_q     <= LW'(NREQ - 1);
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      io_en_q    <= io_en_d;
      io_rw_q    <= io_rw_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
      lat_rw_q   <= lat_rw_d;
      last_q     <= last_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign io_en      = io_en_q;
  assign io_r_or_w  = io_rw_q;
  assign io_addr    = io_addr_q;
  assign io_data_in = io_wdata_q;

endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: self-checking bench for io_arbiter with default parameters
// (NREQ=3, WIDTH=16, ADDR_BITS=4). Directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_io_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, req_rw;
  logic [11:0] req_addr;
  logic [47:0] req_wdata;
  logic [2:0]  gnt, done;
  logic [15:0] rdata;
  logic        busy, io_en, io_r_or_w;
  logic [3:0]  io_addr;
  logic [15:0] io_data_in, io_data_out;

  int n_vec  = 0;
  int n_miss = 0;

  io_arbiter #(.NREQ(3), .WIDTH(16), .ADDR_BITS(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .io_en(io_en), .io_r_or_w(io_r_or_w), .io_addr(io_addr),
    .io_data_in(io_data_in), .io_data_out(io_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Transaction-level reference: a grant at edge g gives io_en after g,
  // read capture at edge g+2 (done visible), return to idle at edge g+3.
  int          ecnt = 0;
  bit          m_act = 1'b0;
  int          m_g = 0;
  int          m_win = 0;
  int          m_last = 2;
  logic        m_rw = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [15:0] m_wd = '0;
  logic [15:0] m_rd = '0;

  function automatic int pick(input logic [2:0] r, input int last);
`ifdef IO_ARB_CORE_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k) % 3;
`ifdef IO_ARB_CORE_PRIO_EN
      if (c == 0) continue;
`endif
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_edge();
    ecnt++;
    if (!rst) begin
      m_act  = 1'b0;
      m_last = 2;
      m_rd   = '0;
    end else if (m_act) begin
      if (ecnt - m_g == 2 && !m_rw) m_rd = io_data_out;
      if (ecnt - m_g == 3) m_act = 1'b0;
    end else if (req != 3'b000) begin
      m_win  = pick(req, m_last);
      m_last = m_win;
      m_act  = 1'b1;
      m_g    = ecnt;
      m_rw   = req_rw[m_win];
      m_addr = req_addr[m_win*4 +: 4];
      m_wd   = req_wdata[m_win*16 +: 16];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [2:0] exp_done();
    return (m_act && ecnt - m_g == 2) ? 3'(1 << m_win) : 3'b000;
  endfunction

  task automatic check_model();
    logic [2:0] eg;
    logic       een;
    eg  = m_act ? 3'(1 << m_win) : 3'b000;
    een = m_act && (ecnt - m_g == 0);
    chk("rnd_gnt",   64'(gnt),   64'(eg));
    chk("rnd_done",  64'(done),  64'(exp_done()));
    chk("rnd_busy",  64'(busy),  64'(m_act));
    chk("rnd_io_en", 64'(io_en), 64'(een));
    chk("rnd_addr",  64'(io_addr), een ? 64'(m_addr) : 64'd0);
    chk("rnd_rdata", 64'(rdata), 64'(m_rd));
    if (een) begin
      chk("rnd_rw",  64'(io_r_or_w),  64'(m_rw));
      chk("rnd_din", 64'(io_data_in), 64'(m_wd));
    end
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  req, rw;
    logic [11:0] addr;
    logic [47:0] wdata;
    logic [15:0] dout;
    logic [2:0]  e_gnt, e_done;
    logic        e_en, e_rw;
    logic [3:0]  e_addr;
    logic [15:0] e_din;
    logic        e_busy;
    logic [15:0] e_rd;
  } vec_t;

  vec_t tv [13];

  task automatic do_reset();
    rst = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0; io_data_out = '0;
    tick();
    rst = 1'b1;
  endtask

  // Holds req for n transactions and checks grant order and 4-cycle spacing.
  task automatic grant_seq(input string nm, input logic [2:0] r, input int n, input logic [11:0] exp);
    logic [2:0] got [4];
    int         at  [4];
    int         cnt;
    logic [2:0] prev;
    do_reset();
    req = r; req_rw = '0; cnt = 0; prev = '0;
    for (int c = 0; c < 4*n + 2; c++) begin
      tick();
      if (gnt != 3'b000 && prev == 3'b000 && cnt < 4) begin
        got[cnt] = gnt; at[cnt] = c; cnt++;
      end
      prev = gnt;
    end
    for (int k = 0; k < n; k++) begin
      logic [11:0] e;
      e = exp;
      if (k < cnt) chk({nm, "_order"}, 64'(got[k]), 64'(e[k*3 +: 3]));
      else         chk({nm, "_missing_grant"}, 64'd0, 64'(e[k*3 +: 3]));
    end
    for (int k = 1; k < n && k < cnt; k++)
      chk({nm, "_spacing"}, 64'(at[k] - at[k-1]), 64'd4);
    req = '0;
    repeat (5) tick();
  endtask

  initial begin
    logic [2:0] pend;
    rst = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0; io_data_out = '0;

    tv[0]  = '{1'b0, 3'b000, 3'b000, 12'h000, 48'h0,    16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000};
    tv[1]  = '{1'b1, 3'b001, 3'b001, 12'h002, 48'hBEEF, 16'h0000, 3'b001, 3'b000, 1'b1, 1'b1, 4'h2, 16'hBEEF, 1'b1, 16'h0000};
    tv[2]  = '{1'b1, 3'b001, 3'b001, 12'h002, 48'hBEEF, 16'h0000, 3'b001, 3'b000, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 16'h0000};
    tv[3]  = '{1'b1, 3'b001, 3'b001, 12'h002, 48'hBEEF, 16'h0000, 3'b001, 3'b001, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 16'h0000};
    tv[4]  = '{1'b1, 3'b000, 3'b000, 12'h000, 48'h0,    16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000};
    tv[5]  = '{1'b1, 3'b010, 3'b000, 12'h050, 48'h0,    16'h0000, 3'b010, 3'b000, 1'b1, 1'b0, 4'h5, 16'h0000, 1'b1, 16'h0000};
    tv[6]  = '{1'b1, 3'b010, 3'b000, 12'h050, 48'h0,    16'hDEAD, 3'b010, 3'b000, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 16'h0000};
    tv[7]  = '{1'b1, 3'b010, 3'b000, 12'h050, 48'h0,    16'h1234, 3'b010, 3'b010, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 16'h1234};
    tv[8]  = '{1'b1, 3'b000, 3'b000, 12'h000, 48'h0,    16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h1234};
    tv[9]  = '{1'b1, 3'b001, 3'b001, 12'h003, 48'h5555, 16'h0000, 3'b001, 3'b000, 1'b1, 1'b1, 4'h3, 16'h5555, 1'b1, 16'h1234};
    tv[10] = '{1'b1, 3'b001, 3'b001, 12'h003, 48'h5555, 16'h0000, 3'b001, 3'b000, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 16'h1234};
    tv[11] = '{1'b1, 3'b001, 3'b001, 12'h003, 48'h5555, 16'hFFFF, 3'b001, 3'b001, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 16'h1234};
    tv[12] = '{1'b1, 3'b000, 3'b000, 12'h000, 48'h0,    16'h0000, 3'b000, 3'b000, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h1234};

    #2;
    for (int i = 0; i < 13; i++) begin
      rst = tv[i].rst; req = tv[i].req; req_rw = tv[i].rw; req_addr = tv[i].addr;
      req_wdata = tv[i].wdata; io_data_out = tv[i].dout;
      tick();
      chk("tv_gnt",   64'(gnt),     64'(tv[i].e_gnt));
      chk("tv_done",  64'(done),    64'(tv[i].e_done));
      chk("tv_io_en", 64'(io_en),   64'(tv[i].e_en));
      chk("tv_addr",  64'(io_addr), 64'(tv[i].e_addr));
      chk("tv_busy",  64'(busy),    64'(tv[i].e_busy));
      chk("tv_rdata", 64'(rdata),   64'(tv[i].e_rd));
      if (tv[i].e_en || !tv[i].rst) begin
        chk("tv_rw",  64'(io_r_or_w),  64'(tv[i].e_rw));
        chk("tv_din", 64'(io_data_in), 64'(tv[i].e_din));
      end
    end

    // Expected orders packed {g3,g2,g1,g0}.
`ifdef IO_ARB_CORE_PRIO_EN
    grant_seq("all_req", 3'b111, 4, {3'b001, 3'b001, 3'b001, 3'b001});
`else
    grant_seq("all_req", 3'b111, 4, {3'b001, 3'b100, 3'b010, 3'b001});
`endif
    grant_seq("aux_req", 3'b110, 3, {3'b000, 3'b010, 3'b100, 3'b010});

    // Reset during ACCESS aborts; round-robin pointer restarts at requester 0.
    do_reset();
    req = 3'b010; req_rw = 3'b010;
    tick();
    chk("rst_pre_gnt", 64'(gnt), 64'(3'b010));
    rst = 1'b0;
    tick();
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_gnt",   64'(gnt),   64'd0);
    chk("rst_io_en", 64'(io_en), 64'd0);
    chk("rst_done",  64'(done),  64'd0);
    rst = 1'b1; req = 3'b011;
    tick();
    chk("rst_next_gnt", 64'(gnt), 64'(3'b001));
    req = 3'b000;
    tick();
    chk("rst_no_done", 64'(done), 64'd0);
    repeat (3) tick();

    // Request dropped and address changed mid-transaction.
    req = 3'b100; req_rw = 3'b000; req_addr = 12'h700;
    tick();
    chk("drop_gnt",  64'(gnt),     64'(3'b100));
    chk("drop_addr", 64'(io_addr), 64'h7);
    req_addr = 12'h900;
    tick();
    chk("drop_cap_en", 64'(io_en), 64'd0);
    req = 3'b000; io_data_out = 16'hABCD;
    tick();
    chk("drop_done",  64'(done),  64'(3'b100));
    chk("drop_rdata", 64'(rdata), 64'hABCD);
    io_data_out = 16'h0;
    tick();
    chk("drop_idle", 64'(busy), 64'd0);

    // Randomized traffic: requests held until their done pulse.
    do_reset();
    pend = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          req_rw[i] = 1'($urandom_range(1));
          req_addr[i*4 +: 4] = 4'($urandom);
          req_wdata[i*16 +: 16] = 16'($urandom);
        end else if ($urandom_range(7) == 0) begin
          req_addr[i*4 +: 4] = 4'($urandom);
          req_wdata[i*16 +: 16] = 16'($urandom);
        end
      end
      req = pend;
      rst = ($urandom_range(99) != 0);
      io_data_out = 16'($urandom);
      tick();
      check_model();
      pend = pend & ~exp_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters; requester 0 is the processor core, 1..NREQ-1 are auxiliary masters (debug, DMA).
REQ-002 Parameter WIDTH, default 16: data width of the I/O port block.
REQ-003 Parameter ADDR_BITS, default 4: I/O port address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester access request, level-held until its done pulse.
REQ-007 req_rw  input  NREQ  per-requester direction; 1 = write, 0 = read.
REQ-008 req_addr  input  NREQ*ADDR_BITS  packed port addresses; slice i belongs to requester i.
REQ-009 req_wdata  input  NREQ*WIDTH  packed write data; slice i belongs to requester i.
REQ-010 gnt  output  NREQ  one-hot grant, all-zero when idle.
REQ-011 done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-012 rdata  output  WIDTH  read data of the last completed read, held until the next read completes.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 io_en  output  1  enable to the I/O port block.
REQ-015 io_r_or_w  output  1  direction to the I/O port block.
REQ-016 io_addr  output  ADDR_BITS  address to the I/O port block; 0 when io_en is low.
REQ-017 io_data_in  output  WIDTH  write data to the I/O port block.
REQ-018 io_data_out  input  WIDTH  read data from the I/O port block, valid the cycle after io_en.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, ACCESS, CAPTURE, DONE.
REQ-020 IDLE: when any req bit is high, the arbiter SHALL select a winner, register gnt, latch that requester's rw/addr/wdata, and move to ACCESS on the same edge; with no requests it SHALL remain in IDLE.
REQ-021 ACCESS: io_en=1 for exactly one cycle, driving the latched rw/addr/wdata; next state CAPTURE.
REQ-022 CAPTURE: io_en=0; for a read, rdata SHALL load io_data_out on the exiting edge; for a write, rdata SHALL be unchanged; next state DONE.
REQ-023 DONE: done[winner]=1 for one cycle; gnt SHALL be held through DONE and cleared on the edge back to IDLE.
REQ-024 Latency: request sampled at edge N -> io_en high during cycle N+1 -> done high during cycle N+3; minimum spacing between transactions is 4 cycles.
REQ-025 Default arbitration SHALL be round-robin: the search starts at last_winner+1 modulo NREQ, and last_winner updates when the request is granted.
REQ-026 Latched rw/addr/wdata SHALL NOT change while busy, whatever happens on the request inputs.
REQ-027 Dropping req during a transaction SHALL NOT abort it; done still pulses.
REQ-028 A request held continuously through DONE SHALL be re-arbitrated in IDLE like any other request.
REQ-029 Requests from non-granted requesters SHALL wait; none SHALL be lost while held.

Reset
REQ-030 With rst low at a rising edge, the block SHALL enter IDLE with gnt=0, done=0, busy=0, io_en=0, io_r_or_w=0, io_addr=0, io_data_in=0, rdata=0, last_winner=NREQ-1.
REQ-031 Reset mid-transaction SHALL abort it: no done pulse, io_en low from the next edge.

Configuration
REQ-032 Macro IO_ARB_CORE_PRIO_EN: when defined, requester 0 SHALL win whenever it requests in IDLE, and the remaining requesters SHALL share round-robin among themselves.
REQ-033 When IO_ARB_CORE_PRIO_EN is undefined, all NREQ requesters SHALL be arbitrated by pure round-robin as in REQ-025.

Verification
REQ-034 After reset, req=3'b001 write, addr=4'h2, wdata=16'hBEEF -> gnt=001 at edge 1; io_en=1, io_addr=2, io_data_in=BEEF during cycle 1; done[0] in cycle 3.
REQ-035 req[1] read, addr=4'h5, io_data_out=16'h1234 in CAPTURE -> rdata=1234 and done[1] pulse; rdata holds 1234 through a later write.
REQ-036 req=3'b111 held continuously (macro undefined) -> grant order 0,1,2,0, one transaction per 4 cycles.
REQ-037 Same stimulus with IO_ARB_CORE_PRIO_EN defined -> requester 0 granted every transaction; with req=3'b110 -> order 1,2,1.
REQ-038 rst low during ACCESS -> next cycle busy=0, gnt=0, io_en=0, no done; a following req[0] is granted first.
REQ-039 req[2] dropped during CAPTURE, req_addr changed mid-transaction -> access uses the original address, done[2] still pulses.
